// File: rtl/stream_cipher_pkg.sv
// Types and constants shared by the stream-cipher output path and its
// handshake FSM.
package stream_cipher_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PROCESSING = 2'd1,
    DONE       = 2'd2
  } interface_state_t;

  typedef enum logic [1:0] {
    H_EMPTY    = 2'd0,
    H_FULL     = 2'd1,
    H_WAIT_ACK = 2'd2
  } holder_state_t;

endpackage

// File: rtl/output_holder.sv
// Holds one ciphertext word and presents it to the chip pins one byte at a
// time, little-endian, until the pins acknowledge the transaction.
module output_holder
  import stream_cipher_pkg::*;
#(
  parameter int BYTES_PER_WORD = stream_cipher_pkg::BYTES_PER_WORD
) (
  input  logic                          clk,
  input  logic                          rst,
  input  interface_state_t              interface_state,
  input  logic [8*BYTES_PER_WORD-1:0]   word_in,
  input  logic                          word_valid,
  output logic                          word_ready,
  input  logic                          byte_read,
  input  logic                          output_acknowledge,
  output logic [7:0]                    data_out,
  output logic [1:0]                    byte_index,
  output logic                          output_is_ready,
  output logic                          overflow_err
);

  localparam int LAST_BYTE = BYTES_PER_WORD - 1;

  holder_state_t               state_reg, state_next;
  logic [8*BYTES_PER_WORD-1:0] held_reg, held_next;
  logic [1:0]                  index_reg, index_next;
  logic                        overflow_reg, overflow_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= H_EMPTY;
      held_reg     <= '0;
      index_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      held_reg     <= held_next;
      index_reg    <= index_next;
      overflow_reg <= overflow_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    held_next       = held_reg;
    index_next      = index_reg;
    overflow_next   = overflow_reg;
    output_is_ready = 1'b0;
    data_out        = 8'h00;
    word_ready      = !rst && (state_reg == H_EMPTY) && (interface_state == PROCESSING);

    // A word offered while we cannot take it is lost; remember that it happened.
    if (word_valid && !word_ready) begin
      overflow_next = 1'b1;
    end

    unique case (state_reg)
      H_EMPTY: begin
        if (word_valid && word_ready) begin
          held_next  = word_in;
          index_next = '0;
          state_next = H_FULL;
        end
      end
      H_FULL: begin
        output_is_ready = 1'b1;
        data_out        = held_reg[8*index_reg +: 8];
        if (output_acknowledge) begin
          state_next = H_EMPTY;
          held_next  = '0;
          index_next = '0;
        end else if (byte_read) begin
          if (index_reg == 2'(LAST_BYTE)) begin
            state_next = H_WAIT_ACK;
            index_next = '0;
          end else begin
            index_next = index_reg + 2'd1;
          end
        end
      end
      H_WAIT_ACK: begin
        output_is_ready = 1'b1;
        if (output_acknowledge) begin
          state_next = H_EMPTY;
          held_next  = '0;
          index_next = '0;
        end
      end
      default: begin
        state_next = H_EMPTY;
      end
    endcase
  end

  assign byte_index   = index_reg;
  assign overflow_err = overflow_reg;

endmodule

// File: tb/tb_output_holder.sv
// Self-checking bench for output_holder: directed scenarios with literal
// expectations, then randomized traffic against a byte-queue model.
module tb_output_holder;
  import stream_cipher_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  interface_state_t interface_state;
  logic [31:0]      word_in;
  logic             word_valid;
  logic             word_ready;
  logic             byte_read;
  logic             output_acknowledge;
  logic [7:0]       data_out;
  logic [1:0]       byte_index;
  logic             output_is_ready;
  logic             overflow_err;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  output_holder #(.BYTES_PER_WORD(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .interface_state    (interface_state),
    .word_in            (word_in),
    .word_valid         (word_valid),
    .word_ready         (word_ready),
    .byte_read          (byte_read),
    .output_acknowledge (output_acknowledge),
    .data_out           (data_out),
    .byte_index         (byte_index),
    .output_is_ready    (output_is_ready),
    .overflow_err       (overflow_err)
  );

  // Model: a word in flight is just the list of bytes not yet read by the pins.
  bit          m_hold = 1'b0;
  logic [7:0]  m_q[$];
  bit          m_ovf  = 1'b0;

  function automatic logic exp_ready();
    return !rst && !m_hold && (interface_state == PROCESSING);
  endfunction

  function automatic logic [7:0] exp_data();
    if (m_hold && m_q.size() > 0) return m_q[0];
    return 8'h00;
  endfunction

  function automatic logic [1:0] exp_index();
    if (m_q.size() == 0) return 2'd0;
    return 2'(4 - m_q.size());
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_check();
    chk("word_ready", 32'(word_ready), 32'(exp_ready()));
    chk("output_is_ready", 32'(output_is_ready), 32'(m_hold));
    chk("data_out", 32'(data_out), 32'(exp_data()));
    chk("byte_index", 32'(byte_index), 32'(exp_index()));
    chk("overflow_err", 32'(overflow_err), 32'(m_ovf));
  endtask

  task automatic model_update();
    logic rdy;
    rdy = exp_ready();
    if (rst) begin
      m_hold = 1'b0;
      m_q.delete();
      m_ovf  = 1'b0;
    end else begin
      if (word_valid && !rdy) m_ovf = 1'b1;
      if (m_hold && output_acknowledge) begin
        m_hold = 1'b0;
        m_q.delete();
      end else if (!m_hold && word_valid && rdy) begin
        m_hold = 1'b1;
        for (int i = 0; i < 4; i++) m_q.push_back(word_in[8*i +: 8]);
        $display("capture word=%08h", word_in);
      end else if (m_hold && byte_read && m_q.size() > 0) begin
        void'(m_q.pop_front());
      end
    end
  endtask

  // One clock: compare mid-cycle, advance the model, step past the edge.
  task automatic cyc();
    @(negedge clk);
    model_check();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    word_valid         = 1'b0;
    byte_read          = 1'b0;
    output_acknowledge = 1'b0;
  endtask

  task automatic capture(input logic [31:0] w);
    interface_state = PROCESSING;
    word_in         = w;
    word_valid      = 1'b1;
    cyc();
    word_valid      = 1'b0;
  endtask

  task automatic read_byte();
    byte_read = 1'b1;
    cyc();
    byte_read = 1'b0;
  endtask

  logic [7:0] exp_bytes [4];

  initial begin
    rst             = 1'b1;
    interface_state = PROCESSING;
    word_in         = 32'hFFFF_FFFF;
    idle_inputs();
    word_valid      = 1'b1;
    #1;
    chk("lit_ready_in_reset", 32'(word_ready), 32'd0);
    cyc();
    cyc();
    rst = 1'b0;
    word_valid = 1'b0;
    #1;
    chk("lit_reset_ready", 32'(output_is_ready), 32'd0);
    chk("lit_reset_data", 32'(data_out), 32'h00);
    chk("lit_reset_ovf", 32'(overflow_err), 32'd0);

    // Capture and read out all four bytes.
    word_in = 32'hA1B2C3D4;
    word_valid = 1'b1;
    #1;
    chk("lit_capture_ready", 32'(word_ready), 32'd1);
    cyc();
    word_valid = 1'b0;
    #1;
    chk("lit_first_ready", 32'(output_is_ready), 32'd1);
    chk("lit_first_data", 32'(data_out), 32'hD4);
    chk("lit_first_index", 32'(byte_index), 32'd0);
    exp_bytes = '{8'hC3, 8'hB2, 8'hA1, 8'h00};
    for (int i = 0; i < 4; i++) begin
      read_byte();
      #1;
      chk("lit_read_data", 32'(data_out), 32'(exp_bytes[i]));
      chk("lit_read_hold", 32'(output_is_ready), 32'd1);
    end
    output_acknowledge = 1'b1;
    cyc();
    output_acknowledge = 1'b0;
    #1;
    chk("lit_ack_release", 32'(output_is_ready), 32'd0);

    // Early acknowledge discards unread bytes.
    capture(32'h5566_7788);
    read_byte();
    read_byte();
    output_acknowledge = 1'b1;
    cyc();
    output_acknowledge = 1'b0;
    #1;
    chk("lit_early_ack_ready", 32'(output_is_ready), 32'd0);
    chk("lit_early_ack_index", 32'(byte_index), 32'd0);
    capture(32'h1122_3344);
    #1;
    chk("lit_second_data", 32'(data_out), 32'h44);

    // Acknowledge beats a simultaneous byte_read.
    byte_read = 1'b1;
    output_acknowledge = 1'b1;
    cyc();
    idle_inputs();
    #1;
    chk("lit_ack_wins_ready", 32'(output_is_ready), 32'd0);
    chk("lit_ack_wins_index", 32'(byte_index), 32'd0);

    // Offer while full: dropped, sticky error.
    capture(32'h0102_0304);
    word_in = 32'hDEAD_BEEF;
    word_valid = 1'b1;
    #1;
    chk("lit_full_ready", 32'(word_ready), 32'd0);
    cyc();
    word_valid = 1'b0;
    #1;
    chk("lit_full_ovf", 32'(overflow_err), 32'd1);
    chk("lit_full_data_kept", 32'(data_out), 32'h04);

    // Reset mid-transaction at byte_index 2.
    read_byte();
    read_byte();
    #1;
    chk("lit_mid_index", 32'(byte_index), 32'd2);
    rst = 1'b1;
    byte_read = 1'b1;
    cyc();
    rst = 1'b0;
    byte_read = 1'b0;
    #1;
    chk("lit_mid_rst_ready", 32'(output_is_ready), 32'd0);
    chk("lit_mid_rst_data", 32'(data_out), 32'h00);
    chk("lit_mid_rst_index", 32'(byte_index), 32'd0);
    chk("lit_mid_rst_ovf", 32'(overflow_err), 32'd0);

    // Offer while IDLE is also an overflow.
    interface_state = IDLE;
    word_valid = 1'b1;
    cyc();
    word_valid = 1'b0;
    #1;
    chk("lit_idle_ovf", 32'(overflow_err), 32'd1);
    chk("lit_idle_empty", 32'(output_is_ready), 32'd0);

    // Randomized traffic, model-checked every cycle.
    for (int n = 0; n < 3000; n++) begin
      rst                = ($urandom_range(0, 63) == 0);
      interface_state    = interface_state_t'(2'($urandom_range(0, 2)));
      word_in            = $urandom;
      word_valid         = ($urandom_range(0, 9) < 3);
      byte_read          = ($urandom_range(0, 1) == 1);
      output_acknowledge = ($urandom_range(0, 11) == 0);
      cyc();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/output_holder.md
OUTPUT_HOLDER -- requirements
Module: output_holder

Interface
REQ-001 Parameter BYTES_PER_WORD, default 4, number of 8-bit bytes per held word; fixed at 4 in this release.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 interface_state  input  interface_state_t  current state of the handshake FSM (IDLE/PROCESSING/DONE).
REQ-005 word_in  input  32  ciphertext word from the keystream XOR stage.
REQ-006 word_valid  input  1  word_in valid this cycle.
REQ-007 word_ready  output  1  holder accepts word_in this cycle.
REQ-008 byte_read  input  1  single-cycle strobe from chip pins: current byte consumed.
REQ-009 output_acknowledge  input  1  chip-pin acknowledge; ends the transaction.
REQ-010 data_out  output  8  byte currently presented to the pins.
REQ-011 byte_index  output  2  index of the byte on data_out.
REQ-012 output_is_ready  output  1  word held and available; drives the handshake FSM.
REQ-013 overflow_err  output  1  sticky: a word was offered while not accepted.

Function
REQ-014 Holder states SHALL be H_EMPTY, H_FULL, H_WAIT_ACK.
REQ-015 word_ready SHALL be 1 only in H_EMPTY with interface_state == PROCESSING (combinational).
REQ-016 H_EMPTY: word_valid && word_ready SHALL capture word_in, clear byte_index to 0, go to H_FULL next cycle.
REQ-017 output_is_ready SHALL be 1 in H_FULL and H_WAIT_ACK, 0 in H_EMPTY; asserts exactly 1 cycle after capture.
REQ-018 H_FULL: data_out SHALL equal held[8*byte_index +: 8], little-endian, byte 0 first.
REQ-019 H_FULL: byte_read SHALL increment byte_index; byte_read at index 3 SHALL go to H_WAIT_ACK with byte_index wrapping to 0.
REQ-020 H_WAIT_ACK and H_EMPTY: data_out SHALL be 0x00; byte_read SHALL be ignored.
REQ-021 output_acknowledge in H_FULL or H_WAIT_ACK SHALL go to H_EMPTY next cycle, clear byte_index and held word; unread bytes discarded.
REQ-022 output_acknowledge in H_EMPTY SHALL have no effect.
REQ-023 Simultaneous output_acknowledge and byte_read: acknowledge wins.
REQ-024 Simultaneous capture and output_acknowledge in H_EMPTY: capture proceeds.
REQ-025 word_valid while word_ready == 0 SHALL set overflow_err; word dropped, state unchanged.
REQ-026 overflow_err SHALL clear only on reset.
REQ-027 interface_state SHALL only gate word_ready; it SHALL NOT force holder transitions.

Reset
REQ-028 rst high at a rising edge SHALL give H_EMPTY, held word 0, byte_index 0, data_out 0x00, output_is_ready 0, overflow_err 0.
REQ-029 Reset SHALL take priority over all other inputs, including mid-transaction in H_FULL/H_WAIT_ACK.
REQ-030 word_ready SHALL be 0 while rst is high.

Structure
REQ-031 interface_state_t, holder_state_t and BYTES_PER_WORD SHALL live in shared package stream_cipher_pkg; interface_fsm imports the same typedef.
REQ-032 Single module, no sub-module; byte mux inline.
REQ-033 One always_ff for state/registers, one always_comb for next-state and outputs; unique case with explicit default to H_EMPTY.

Verification
REQ-034 Reset then PROCESSING, word_in=0xA1B2C3D4 valid 1 cycle -> word_ready=1 that cycle; next cycle output_is_ready=1, data_out=0xD4, byte_index=0.
REQ-035 Four byte_read strobes after REQ-034 -> data_out D4,C3,B2,A1 then 0x00 in H_WAIT_ACK; output_is_ready stays 1; ack -> output_is_ready=0 next cycle.
REQ-036 Ack after two byte_reads -> H_EMPTY next cycle, byte_index=0; subsequent word 0x11223344 captured, data_out=0x44.
REQ-037 word_valid during H_FULL, or with interface_state=IDLE -> word_ready=0, overflow_err=1 and stays 1 until rst.
REQ-038 Same-cycle ack and byte_read in H_FULL -> H_EMPTY, byte_index=0.
REQ-039 rst asserted in H_FULL at byte_index=2 -> next cycle all outputs at reset values.
